// File: rtl/spi_sd_responder.sv
// SPI mode-0 SD-card responder: oversampled pins, 48-bit command frame parser
// with CRC7 check, and a small response-byte FIFO shifted out on miso.
module spi_sd_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RESP_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs,
  input  logic        i_sclk,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic        o_cs_active,
  output logic        o_cmd_valid,
  output logic [5:0]  o_cmd_idx,
  output logic [31:0] o_cmd_arg,
  output logic        o_cmd_crc_ok,
  input  logic        i_resp_valid,
  input  logic [7:0]  i_resp_data,
  output logic        o_resp_ready
);

  localparam int unsigned AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARG, ST_CRC} state_e;

  // CRC7, polynomial x^7 + x^3 + 1, MSB first
  function automatic logic [6:0] crc7_upd(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_p_q, cs_p_d;
  logic                   sclk_p_q, sclk_p_d;
  logic                   cs_active_q, cs_active_d;
  logic                   miso_q, miso_d;
  logic [7:0]             rx_sr_q, rx_sr_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             tx_sr_q, tx_sr_d;
  logic [7:0]             mem_q [RESP_DEPTH];
  logic [7:0]             mem_d [RESP_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  state_e                 state_q, state_d;
  logic [1:0]             arg_cnt_q, arg_cnt_d;
  logic [5:0]             idx_q, idx_d;
  logic [31:0]            arg_q, arg_d;
  logic [6:0]             crc_q, crc_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [5:0]             cmd_idx_q, cmd_idx_d;
  logic [31:0]            cmd_arg_q, cmd_arg_d;
  logic                   cmd_crc_ok_q, cmd_crc_ok_d;

  logic       cs_s, sclk_s, mosi_s;
  logic       cs_act, cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic       byte_done, load, push, pop;
  logic [7:0] rx_byte;

  assign o_resp_ready = (count_q != CW'(RESP_DEPTH)) && !i_rst;
  assign o_miso       = miso_q;
  assign o_cs_active  = cs_active_q;
  assign o_cmd_valid  = cmd_valid_q;
  assign o_cmd_idx    = cmd_idx_q;
  assign o_cmd_arg    = cmd_arg_q;
  assign o_cmd_crc_ok = cmd_crc_ok_q;

  always_comb begin
    cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], i_cs};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    cs_s         = cs_sync_q[SYNC_STAGES-1];
    sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    mosi_s       = mosi_sync_q[SYNC_STAGES-1];
    cs_p_d       = cs_s;
    sclk_p_d     = sclk_s;
    cs_act       = ~cs_s;
    cs_fall      = ~cs_s & cs_p_q;
    cs_rise      = cs_s & ~cs_p_q;
    sclk_rise    = sclk_s & ~sclk_p_q;
    sclk_fall    = ~sclk_s & sclk_p_q;
    cs_active_d  = cs_act;

    rx_sr_d      = rx_sr_q;
    bit_cnt_d    = bit_cnt_q;
    tx_sr_d      = tx_sr_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    arg_cnt_d    = arg_cnt_q;
    idx_d        = idx_q;
    arg_d        = arg_q;
    crc_d        = crc_q;
    cmd_valid_d  = 1'b0;
    cmd_idx_d    = cmd_idx_q;
    cmd_arg_d    = cmd_arg_q;
    cmd_crc_ok_d = cmd_crc_ok_q;
    byte_done    = 1'b0;
    rx_byte      = {rx_sr_q[6:0], mosi_s};

    if (cs_act && sclk_rise) begin
      rx_sr_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end

    // TX reload at frame start and at each byte boundary, else shift in ones
    load = cs_fall | (cs_act & sclk_fall & (bit_cnt_q == 3'd0));
    pop  = load & (count_q != '0);
    push = i_resp_valid & o_resp_ready;
    if (load) begin
      tx_sr_d = pop ? mem_q[rd_ptr_q] : 8'hFF;
    end else if (cs_act && sclk_fall) begin
      tx_sr_d = {tx_sr_q[6:0], 1'b1};
    end

    if (push) begin
      mem_d[wr_ptr_q] = i_resp_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    if (byte_done) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte[7:6] == 2'b01) begin
            idx_d     = rx_byte[5:0];
            crc_d     = crc7_upd(7'd0, rx_byte);
            arg_cnt_d = 2'd0;
            state_d   = ST_ARG;
          end
        end
        ST_ARG: begin
          arg_d     = {arg_q[23:0], rx_byte};
          crc_d     = crc7_upd(crc_q, rx_byte);
          arg_cnt_d = arg_cnt_q + 2'd1;
          if (arg_cnt_q == 2'd3) state_d = ST_CRC;
        end
        ST_CRC: begin
          cmd_valid_d  = 1'b1;
          cmd_idx_d    = idx_q;
          cmd_arg_d    = arg_q;
          cmd_crc_ok_d = (rx_byte[7:1] == crc_q) && rx_byte[0];
          state_d      = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // cs release abandons any partial byte/frame and the in-flight TX byte
    if (cs_rise) begin
      bit_cnt_d = 3'd0;
      rx_sr_d   = 8'd0;
      tx_sr_d   = 8'hFF;
      state_d   = ST_IDLE;
    end

    miso_d = cs_s ? 1'b1 : tx_sr_d[7];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cs_sync_q    <= '1;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      cs_p_q       <= 1'b1;
      sclk_p_q     <= 1'b0;
      cs_active_q  <= 1'b0;
      miso_q       <= 1'b1;
      rx_sr_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      tx_sr_q      <= 8'hFF;
      for (int i = 0; i < int'(RESP_DEPTH); i++) mem_q[i] <= 8'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      arg_cnt_q    <= 2'd0;
      idx_q        <= 6'd0;
      arg_q        <= 32'd0;
      crc_q        <= 7'd0;
      cmd_valid_q  <= 1'b0;
      cmd_idx_q    <= 6'd0;
      cmd_arg_q    <= 32'd0;
      cmd_crc_ok_q <= 1'b0;
    end else begin
      cs_sync_q    <= cs_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_p_q       <= cs_p_d;
      sclk_p_q     <= sclk_p_d;
      cs_active_q  <= cs_active_d;
      miso_q       <= miso_d;
      rx_sr_q      <= rx_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_sr_q      <= tx_sr_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      arg_cnt_q    <= arg_cnt_d;
      idx_q        <= idx_d;
      arg_q        <= arg_d;
      crc_q        <= crc_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_idx_q    <= cmd_idx_d;
      cmd_arg_q    <= cmd_arg_d;
      cmd_crc_ok_q <= cmd_crc_ok_d;
    end
  end

endmodule

// File: tb/tb_spi_sd_responder.sv
// Directed bench for spi_sd_responder: SD command frames, CRC/end-bit errors,
// response FIFO ordering and backpressure, cs abort and mid-frame reset.
module tb_spi_sd_responder;

  localparam int H = 6;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b1;
  logic        miso;
  logic        cs_active;
  logic        cmd_valid;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        cmd_crc_ok;
  logic        resp_valid = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic        resp_ready;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  logic [7:0] r;

  spi_sd_responder #(.SYNC_STAGES(2), .RESP_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_sclk(sclk), .i_mosi(mosi),
    .o_miso(miso), .o_cs_active(cs_active), .o_cmd_valid(cmd_valid),
    .o_cmd_idx(cmd_idx), .o_cmd_arg(cmd_arg), .o_cmd_crc_ok(cmd_crc_ok),
    .i_resp_valid(resp_valid), .i_resp_data(resp_data), .o_resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  // Each cycle with cmd_valid high counts once, so one pulse per frame => +1
  always @(negedge clk) if (cmd_valid === 1'b1) pulses++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = d[i];
      cyc(H);
      rx[i] = miso;
      sclk = 1'b1;
      cyc(H);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] d, output logic [7:0] rx);
    spi_bits(d, 8, rx);
  endtask

  task automatic send6(input logic [47:0] f, output logic [7:0] first);
    logic [7:0] t;
    for (int k = 0; k < 6; k++) begin
      spi_byte(f[47-8*k -: 8], t);
      if (k == 0) first = t;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    cyc(H);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    mosi = 1'b1;
    cyc(H);
  endtask

  task automatic push(input logic [7:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    cyc(1);
    resp_valid = 1'b0;
  endtask

  initial begin
    // reset values
    cyc(3);
    chk("rst_miso", 32'(miso), 32'd1);
    chk("rst_cs_active", 32'(cs_active), 32'd0);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_idx", 32'(cmd_idx), 32'd0);
    chk("rst_arg", cmd_arg, 32'd0);
    chk("rst_crc_ok", 32'(cmd_crc_ok), 32'd0);
    chk("rst_ready", 32'(resp_ready), 32'd0);
    rst = 1'b0;
    cyc(4);
    chk("ready_after_rst", 32'(resp_ready), 32'd1);

    // CMD0
    p0 = pulses;
    cs_low();
    chk("cs_active_low", 32'(cs_active), 32'd1);
    send6(48'h40_00_00_00_00_95, r);
    chk("cmd0_rx_idle_fill", 32'(r), 32'hFF);
    cs_high();
    chk("cs_active_high", 32'(cs_active), 32'd0);
    chk("cmd0_pulses", 32'(pulses - p0), 32'd1);
    chk("cmd0_idx", 32'(cmd_idx), 32'd0);
    chk("cmd0_arg", cmd_arg, 32'h0000_0000);
    chk("cmd0_crc_ok", 32'(cmd_crc_ok), 32'd1);

    // CMD8 preceded by two idle 0xFF bytes
    p0 = pulses;
    cs_low();
    spi_byte(8'hFF, r);
    spi_byte(8'hFF, r);
    chk("ff_no_pulse", 32'(pulses - p0), 32'd0);
    send6(48'h48_00_00_01_AA_87, r);
    cs_high();
    chk("cmd8_pulses", 32'(pulses - p0), 32'd1);
    chk("cmd8_idx", 32'(cmd_idx), 32'd8);
    chk("cmd8_arg", cmd_arg, 32'h0000_01AA);
    chk("cmd8_crc_ok", 32'(cmd_crc_ok), 32'd1);

    // CMD17 with a zero CRC byte
    p0 = pulses;
    cs_low();
    send6(48'h51_00_00_02_00_00, r);
    cs_high();
    chk("cmd17_pulses", 32'(pulses - p0), 32'd1);
    chk("cmd17_idx", 32'(cmd_idx), 32'd17);
    chk("cmd17_arg", cmd_arg, 32'h0000_0200);
    chk("cmd17_crc_ok", 32'(cmd_crc_ok), 32'd0);

    // CMD0 with correct CRC7 but end bit 0
    p0 = pulses;
    cs_low();
    send6(48'h40_00_00_00_00_94, r);
    cs_high();
    chk("endbit_pulses", 32'(pulses - p0), 32'd1);
    chk("endbit_idx", 32'(cmd_idx), 32'd0);
    chk("endbit_crc_ok", 32'(cmd_crc_ok), 32'd0);

    // Response bytes pushed ahead of the cs window
    push(8'h01);
    push(8'hFE);
    cyc(2);
    chk("miso_idle_cs_high", 32'(miso), 32'd1);
    cs_low();
    spi_byte(8'hFF, r);
    chk("resp_byte0", 32'(r), 32'h01);
    spi_byte(8'hFF, r);
    chk("resp_byte1", 32'(r), 32'hFE);
    spi_byte(8'hFF, r);
    chk("resp_byte2_fill", 32'(r), 32'hFF);
    cs_high();
    chk("miso_after_cs", 32'(miso), 32'd1);

    // Backpressure: depth 4, fifth push refused
    for (int i = 0; i < 5; i++) begin
      resp_valid = 1'b1;
      resp_data  = 8'hA0 + 8'(i);
      chk("fill_ready", 32'(resp_ready), (i < 4) ? 32'd1 : 32'd0);
      cyc(1);
    end
    resp_valid = 1'b0;
    cyc(1);
    chk("full_ready", 32'(resp_ready), 32'd0);
    cs_low();
    chk("ready_after_pop", 32'(resp_ready), 32'd1);
    cs_high();

    // Partial frame aborted by cs; remaining FIFO bytes survive
    p0 = pulses;
    cs_low();
    spi_byte(8'h40, r);
    chk("retained_a1", 32'(r), 32'hA1);
    spi_byte(8'h00, r);
    chk("retained_a2", 32'(r), 32'hA2);
    spi_byte(8'h00, r);
    chk("retained_a3", 32'(r), 32'hA3);
    spi_bits(8'h00, 4, r);
    cs_high();
    chk("abort_no_pulse", 32'(pulses - p0), 32'd0);
    cs_low();
    send6(48'h40_00_00_00_00_95, r);
    cs_high();
    chk("after_abort_pulses", 32'(pulses - p0), 32'd1);
    chk("after_abort_idx", 32'(cmd_idx), 32'd0);
    chk("after_abort_crc_ok", 32'(cmd_crc_ok), 32'd1);

    // Reset in the middle of a frame with bytes queued
    cs_low();
    send6(48'h48_00_00_01_AA_87, r);
    spi_byte(8'h48, r);
    spi_byte(8'h00, r);
    push(8'h5A);
    push(8'h5B);
    rst = 1'b1;
    cyc(2);
    cs = 1'b1;
    chk("mid_rst_miso", 32'(miso), 32'd1);
    chk("mid_rst_cs_active", 32'(cs_active), 32'd0);
    chk("mid_rst_idx", 32'(cmd_idx), 32'd0);
    chk("mid_rst_arg", cmd_arg, 32'd0);
    chk("mid_rst_crc_ok", 32'(cmd_crc_ok), 32'd0);
    chk("mid_rst_ready", 32'(resp_ready), 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(4);
    chk("post_rst_ready", 32'(resp_ready), 32'd1);
    p0 = pulses;
    cs_low();
    send6(48'h48_00_00_01_AA_87, r);
    chk("post_rst_fifo_empty", 32'(r), 32'hFF);
    cs_high();
    chk("post_rst_pulses", 32'(pulses - p0), 32'd1);
    chk("post_rst_idx", 32'(cmd_idx), 32'd8);
    chk("post_rst_arg", cmd_arg, 32'h0000_01AA);
    chk("post_rst_crc_ok", 32'(cmd_crc_ok), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_sd_responder.md
Name: spi_sd_responder

Overview:
SPI mode-0 slave that models the SD-card end of the SoC's SPI SD-card link (cs/sclk/mosi in, miso out), for use in simulation top-levels and FPGA loopback test rigs.
- Oversamples the master's pins in its own clock domain.
- Parses 48-bit SD command frames, checking CRC7, and presents each as a one-cycle pulse to user logic.
- Transmits response bytes that user logic pushes through a small FIFO. Idle fill is 0xFF.

Parameters:
SYNC_STAGES, 2, flip-flop stages on i_cs, i_sclk and i_mosi (min 2).
RESP_DEPTH, 4, response FIFO depth in bytes (power of 2, min 2).

Ports:
i_clk  in  1  block clock; all logic on rising edge.
i_rst  in  1  reset.
i_cs  in  1  SPI chip select from master, active low, asynchronous.
i_sclk  in  1  SPI clock from master, asynchronous.
i_mosi  in  1  master-out data, asynchronous.
o_miso  out  1  slave-out data.
o_cs_active  out  1  synchronized chip select asserted (cs low).
o_cmd_valid  out  1  one-cycle pulse: complete command frame received.
o_cmd_idx  out  6  command index, frame bits [45:40].
o_cmd_arg  out  32  argument, frame bits [39:8].
o_cmd_crc_ok  out  1  CRC7 matches and end bit = 1.
i_resp_valid  in  1  push response byte.
i_resp_data  in  8  response byte.
o_resp_ready  out  1  FIFO can accept a byte.

Behaviour:
Reset and clocking:
- Clock i_clk. Reset i_rst is synchronous and active-high.
- While i_rst = 1, every register clears: o_miso=1, o_cs_active=0, o_cmd_valid=0, o_cmd_idx=0, o_cmd_arg=0, o_cmd_crc_ok=0, FIFO empty, o_resp_ready=0 (gated by i_rst).
- o_resp_ready = !full && !i_rst. A push is accepted when i_resp_valid && o_resp_ready.
- If a push and a pop occur in the same cycle with the FIFO full, the push is not accepted, because ready reflects the pre-pop state.

Input timing:
- Inputs pass through SYNC_STAGES flops. Edges are detected by comparing the last two synchronized samples.
- Timing requirement: sclk high and low phases are each >= SYNC_STAGES+2 i_clk cycles. Behaviour is undefined otherwise.

RX (detected rising sclk edge while cs is active):
- Shift synchronized mosi into an 8-bit register, MSB first, and increment a 3-bit bit counter.
- When the counter wraps 7->0, a byte is complete.

TX:
- o_miso is bit 7 of an 8-bit TX shift register.
- Load event: a detected cs assertion, or a falling sclk edge with bit counter == 0.
  - On a load event, pop the FIFO head into the TX register if the FIFO is non-empty; otherwise load 0xFF.
- Any other falling sclk edge while cs is active shifts the register left and fills with 1.
- While cs is inactive, o_miso = 1.

Command parser FSM (advances on byte completion):
- IDLE: if byte[7:6] == 2'b01, latch idx = byte[5:0], start CRC7 over the byte, go to ARG with arg byte count 0. Any other byte (including 0xFF) is ignored.
- ARG: shift the byte into arg (MSB first) and continue CRC7. After the 4th byte go to CRC.
- CRC: on byte completion, the next cycle drives o_cmd_valid=1 for exactly one cycle, with idx and arg stable. Then return to IDLE.
  - o_cmd_crc_ok = (byte[7:1] == CRC7 of the 40 preceding bits) && byte[0] == 1.
- CRC7: polynomial x^7+x^3+1, initial value 0, MSB first.
- o_cmd_idx, o_cmd_arg and o_cmd_crc_ok hold their values until the next o_cmd_valid.

CS deassert (detected rising edge of synchronized cs):
- Bit counter clears to 0, the FSM returns to IDLE, and the partial byte is discarded.
- No o_cmd_valid is produced for a partial frame.
- The current TX byte is lost. Remaining FIFO entries are retained.
- Reasserting cs starts a fresh byte alignment.

Simultaneous events: a pop on a load event and an accepted push in the same cycle are both performed, so the count is unchanged.

Test Plan:
- CMD0, bytes 40 00 00 00 00 95, one cs window -> single o_cmd_valid pulse with idx=0, arg=0x00000000, crc_ok=1.
- CMD8 with two leading 0xFF bytes, then 48 00 00 01 AA 87 -> idx=8, arg=0x000001AA, crc_ok=1. The 0xFF bytes produce no pulse.
- CMD17, 51 00 00 02 00 00 (bad CRC) -> idx=17, arg=0x00000200, crc_ok=0. A variant with correct CRC bits but end bit 0 also gives crc_ok=0.
- Push 0x01 and 0xFE before cs assert, then master clocks 3 bytes -> master reads 0x01, 0xFE, 0xFF. o_miso=1 outside cs.
- Push 5 bytes back-to-back with no SPI traffic, depth 4 -> the first 4 are accepted, o_resp_ready=0 on the 5th. One cs assert pops one byte and ready returns to 1.
- Send 40 00 00, deassert cs mid-4th-byte, reassert, send a full CMD0 frame -> exactly one o_cmd_valid pulse (idx=0, crc_ok=1). Assert i_rst mid-frame -> all outputs return to reset values, FIFO is empty, and the next frame decodes normally.
